ingress_fifo: RTL and testbench



---
 rtl/ingress_fifo_pkg.sv | 15 +
 rtl/ingress_fifo_mem.sv | 25 ++
 rtl/ingress_fifo.sv | 113 +++++++++++
 tb/tb_ingress_fifo.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ingress_fifo_pkg.sv
// Shared definitions for the ingress buffer and the router stages that consume it.
// Holds default geometry, the destination tag field position and the occupancy width helper.
package ingress_fifo_pkg;

  localparam int DEF_WIDTH = 10;
  localparam int DEF_DEPTH = 8;
  localparam int TAG_MSB   = 9;
  localparam int TAG_LSB   = 8;

  // Occupancy needs one more bit than the pointers so that DEPTH itself is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ingress_fifo_mem.sv
// DEPTH x WIDTH register file: synchronous write port, asynchronous read port, no reset.
module ingress_fifo_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ingress_fifo.sv
// Per-lane input buffer in front of the router: pointers, occupancy, registered flags,
// sticky misuse error and the registered head-word output.
module ingress_fifo
  import ingress_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 2,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [CNT_W-1:0] count,
  output logic             error
);

  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(DEPTH - AF_THRESH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             valid_out_q, valid_out_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             ae_q, ae_d;
  logic             af_q, af_d;
  logic             error_q, error_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] rdata;

  ingress_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok),
    .waddr (wr_ptr_q),
    .wdata (data_in),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  always_comb begin
    pop_ok  = pop & ~empty_q;
    // A pop on a full buffer frees the slot the simultaneous push needs.
    push_ok = push & (~full_q | pop_ok);

    wr_ptr_d    = wr_ptr_q + AW'(push_ok);
    rd_ptr_d    = rd_ptr_q + AW'(pop_ok);
    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    data_out_d  = pop_ok ? rdata : data_out_q;
    valid_out_d = pop_ok;

    // Flags follow the next occupancy so they line up with count.
    empty_d = (count_d == '0);
    full_d  = (count_d == FULL_LVL);
    ae_d    = (count_d <= AE_LVL);
    af_d    = (count_d >= AF_LVL);

    error_d = error_q | (push & ~push_ok) | (pop & ~pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      ae_q        <= 1'b1;
      af_q        <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      empty_q     <= empty_d;
      full_q      <= full_d;
      ae_q        <= ae_d;
      af_q        <= af_d;
      error_q     <= error_d;
    end
  end

  assign data_out     = data_out_q;
  assign valid_out    = valid_out_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_empty = ae_q;
  assign almost_full  = af_q;
  assign count        = count_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ingress_fifo.sv
// Self-checking bench for ingress_fifo: directed boundary scenarios plus random traffic,
// all checked against a queue-based reference model.
module tb_ingress_fifo;

  localparam int WIDTH = 10;
  localparam int DEPTH = 8;
  localparam int AE_T  = 1;
  localparam int AF_T  = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             valid_out, empty, full, almost_empty, almost_full, error;
  logic [CNT_W-1:0] count;

  int n_total = 0;
  int n_bad   = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_dout = '0;
  logic             exp_valid = 1'b0;
  logic             exp_err = 1'b0;

  ingress_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AE_THRESH(AE_T), .AF_THRESH(AF_T)
  ) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .almost_empty(almost_empty), .almost_full(almost_full), .count(count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ph);
    int n;
    n = q.size();
    check_val({ph, ":data_out"}, 32'(data_out), 32'(exp_dout));
    check_val({ph, ":valid_out"}, 32'(valid_out), 32'(exp_valid));
    check_val({ph, ":count"}, 32'(count), 32'(n));
    check_val({ph, ":empty"}, 32'(empty), 32'(n == 0));
    check_val({ph, ":full"}, 32'(full), 32'(n == DEPTH));
    check_val({ph, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE_T));
    check_val({ph, ":almost_full"}, 32'(almost_full), 32'(n >= DEPTH - AF_T));
    check_val({ph, ":error"}, 32'(error), 32'(exp_err));
  endtask

  // Async reset applied mid-cycle; outputs must be at reset values before any edge.
  task automatic do_reset(input string ph);
    #2;
    reset = 1'b1;
    q.delete();
    exp_dout = '0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    #1;
    check_outputs({ph, ":rst"});
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic p, input logic [WIDTH-1:0] d, input logic r, input string ph);
    logic pok, wok;
    push = p;
    data_in = d;
    pop = r;
    @(posedge clk);
    pok = r && (q.size() > 0);
    wok = p && ((q.size() < DEPTH) || pok);
    exp_valid = pok;
    if (pok) exp_dout = q.pop_front();
    if (wok) q.push_back(d);
    if ((p && !wok) || (r && !pok)) exp_err = 1'b1;
    #1;
    push = 1'b0;
    pop = 1'b0;
    $display("%s: push=%0b din=%03h pop=%0b -> dout=%03h v=%0b cnt=%0d err=%0b",
             ph, p, d, r, data_out, valid_out, count, error);
    check_outputs(ph);
  endtask

  initial begin
    reset = 1'b1;
    #1;
    check_outputs("init");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // T1: reset with five words stored
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'(10'h010 + i), 1'b0, "t1_fill");
    do_reset("t1");
    cycle(1'b0, '0, 1'b1, "t1_pop");

    // T2: fill and drain
    do_reset("t2");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(10'h101 + i), 1'b0, "t2_push");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, "t2_pop");
      check_val("t2_order", 32'(data_out), 32'(10'h101 + i));
    end

    // T3: overflow drops the word
    do_reset("t3");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(10'h120 + i), 1'b0, "t3_fill");
    cycle(1'b1, 10'h3FF, 1'b0, "t3_ovf");
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, '0, 1'b1, "t3_pop");
      check_val("t3_no3ff", 32'(data_out == 10'h3FF), 32'd0);
    end

    // T4: push and pop together at full
    do_reset("t4");
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'(10'h140 + i), 1'b0, "t4_fill");
    cycle(1'b1, 10'h2AA, 1'b1, "t4_both");
    check_val("t4_head", 32'(data_out), 32'h140);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "t4_pop");
    check_val("t4_last", 32'(data_out), 32'h2AA);

    // T5: pointer wrap at count=1, then underflow with simultaneous push
    do_reset("t5");
    cycle(1'b1, 10'h200, 1'b0, "t5_seed");
    for (int i = 1; i <= 20; i++) cycle(1'b1, WIDTH'(10'h200 + i), 1'b1, "t5_pair");
    cycle(1'b0, '0, 1'b1, "t5_drain");
    cycle(1'b1, 10'h055, 1'b1, "t5_unf");
    cycle(1'b0, '0, 1'b1, "t5_pop");
    check_val("t5_055", 32'(data_out), 32'h055);

    // T6: random traffic, with occasional mid-run resets
    do_reset("t6");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset("t6");
      cycle(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)), "t6");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
